// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the 3x3 convolution layer sequencer.
package conv_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_FILL    = 3'd2,
      S_STREAM  = 3'd3,
      S_DRAIN   = 3'd4,
      S_NEXT_IC = 3'd5,
      S_NEXT_OC = 3'd6,
      S_DONE    = 3'd7
   } seq_state_t;

   localparam int DEF_IMG_W    = 224;
   localparam int DEF_IMG_H    = 224;
   localparam int DEF_CH_W     = 7;
   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_KADDR_W  = 14;
   localparam int DEF_PIPE_LAT = 4;

   // A window at stream offset k is real (not straddling the padded border)
   // when its column within the padded row lies inside the unpadded width.
   function automatic logic col_valid(input int k, input int pw, input int img_w);
      return (k % pw) < img_w;
   endfunction

endpackage

// File: rtl/conv_seq_wr_delay.sv
// Write-strobe delay line that models PE pipeline latency; freezes on
// back-pressure and is emptied on abort.
module conv_seq_wr_delay
   import conv_seq_pkg::*;
#(
   parameter int DEPTH = DEF_PIPE_LAT
) (
   input  logic clk,
   input  logic reset,
   input  logic hold,
   input  logic clear,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] stages;

   // Shift one stage per unstalled cycle; abort drops everything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stages <= '0;
      end else if (clear) begin
         stages <= '0;
      end else if (!hold) begin
         stages <= (stages << 1) | DEPTH'(din);
      end
   end

   assign dout = stages[DEPTH-1];

endmodule

// File: rtl/conv_layer_sequencer.sv
// Sequencer for 3x3 stride-1 convolution layers: walks out-channels and
// in-channels, streams each zero-padded plane through the line buffer and
// schedules the output-RAM writes once the PE pipeline has produced them.
module conv_layer_sequencer
   import conv_seq_pkg::*;
#(
   parameter int IMG_W    = DEF_IMG_W,
   parameter int IMG_H    = DEF_IMG_H,
   parameter int CH_W     = DEF_CH_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int KADDR_W  = DEF_KADDR_W,
   parameter int PIPE_LAT = DEF_PIPE_LAT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [CH_W-1:0]    cfg_in_ch,
   input  logic [CH_W-1:0]    cfg_out_ch,
   input  logic               abort,
   input  logic               stall,
   output logic               busy,
   output logic               done,
   output logic               in_rd_en,
   output logic [ADDR_W-1:0]  in_addr,
   output logic [CH_W-1:0]    in_ch,
   output logic [KADDR_W-1:0] kernel_addr,
   output logic [CH_W-1:0]    bias_addr,
   output logic               win_valid,
   output logic               acc_first,
   output logic               acc_last,
   output logic               out_wr_en,
   output logic [ADDR_W-1:0]  out_addr,
   output logic [CH_W-1:0]    out_ch
);

   localparam int PW       = IMG_W + 2;
   localparam int PH       = IMG_H + 2;
   localparam int PLANE    = PW * PH;
   localparam int FILL_LEN = 2 * PW + 2;
   localparam int DRAIN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   localparam logic [ADDR_W-1:0]  FILL_LAST  = ADDR_W'(FILL_LEN - 1);
   localparam logic [ADDR_W-1:0]  PLANE_LAST = ADDR_W'(PLANE - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

   seq_state_t state, state_nxt;

   logic [CH_W-1:0]    cfg_in_ch_r, cfg_out_ch_r;
   logic [CH_W-1:0]    ic, oc;
   logic [ADDR_W-1:0]  rd_addr, wr_addr;
   logic [KADDR_W-1:0] kaddr;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               win_pend;
   logic               dl_out;
   logic               can_step;
   logic               last_ic, last_oc, cfg_zero;
   logic               fill_entry;

   assign can_step   = !stall && !abort;
   assign last_ic    = (ic == cfg_in_ch_r - CH_W'(1));
   assign last_oc    = (oc == cfg_out_ch_r - CH_W'(1));
   assign cfg_zero   = (cfg_in_ch_r == '0) || (cfg_out_ch_r == '0);
   assign fill_entry = can_step && (state_nxt == S_FILL) && (state != S_FILL);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and strobes; stall freezes every state except IDLE/DONE.
   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE) && !abort;
      in_rd_en  = can_step && ((state == S_FILL) || (state == S_STREAM));
      win_valid = can_step && win_pend;
      acc_first = win_valid && (ic == '0);
      acc_last  = win_valid && last_ic;
      out_wr_en = can_step && dl_out;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:    if (start) state_nxt = S_LOAD;
            S_LOAD:    if (!stall) state_nxt = cfg_zero ? S_DONE : S_FILL;
            S_FILL:    if (!stall && rd_addr == FILL_LAST) state_nxt = S_STREAM;
            S_STREAM:  if (!stall && rd_addr == PLANE_LAST) state_nxt = S_DRAIN;
            S_DRAIN: begin
               if (!stall && drain_cnt == DRAIN_LAST) begin
                  if (!last_ic)      state_nxt = S_NEXT_IC;
                  else if (!last_oc) state_nxt = S_NEXT_OC;
                  else               state_nxt = S_DONE;
               end
            end
            S_NEXT_IC: if (!stall) state_nxt = S_FILL;
            S_NEXT_OC: if (!stall) state_nxt = S_FILL;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   // Channel loop counters, read/write addresses and the window pipeline bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_in_ch_r  <= '0;
         cfg_out_ch_r <= '0;
         ic           <= '0;
         oc           <= '0;
         kaddr        <= '0;
         rd_addr      <= '0;
         wr_addr      <= '0;
         drain_cnt    <= '0;
         win_pend     <= 1'b0;
      end else if (abort) begin
         ic        <= '0;
         oc        <= '0;
         kaddr     <= '0;
         rd_addr   <= '0;
         wr_addr   <= '0;
         drain_cnt <= '0;
         win_pend  <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            cfg_in_ch_r  <= cfg_in_ch;
            cfg_out_ch_r <= cfg_out_ch;
            ic           <= '0;
            oc           <= '0;
            kaddr        <= '0;
            rd_addr      <= '0;
            wr_addr      <= '0;
            drain_cnt    <= '0;
         end
         if (!stall) begin
            win_pend <= (state == S_STREAM) &&
                        col_valid(int'(rd_addr) - FILL_LEN, PW, IMG_W);
            unique case (state)
               S_FILL, S_STREAM: begin
                  if (rd_addr != PLANE_LAST) rd_addr <= rd_addr + ADDR_W'(1);
               end
               S_DRAIN: begin
                  drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + DRAIN_W'(1);
               end
               S_NEXT_IC: begin
                  ic    <= ic + CH_W'(1);
                  kaddr <= kaddr + KADDR_W'(1);
               end
               S_NEXT_OC: begin
                  ic    <= '0;
                  oc    <= oc + CH_W'(1);
                  kaddr <= kaddr + KADDR_W'(1);
               end
               default: ;
            endcase
         end
         if (fill_entry) begin
            rd_addr <= '0;
            wr_addr <= '0;
         end else if (out_wr_en) begin
            wr_addr <= wr_addr + ADDR_W'(1);
         end
      end
   end

   conv_seq_wr_delay #(
      .DEPTH (PIPE_LAT)
   ) u_wr_delay (
      .clk   (clk),
      .reset (reset),
      .hold  (stall),
      .clear (abort),
      .din   (acc_last),
      .dout  (dl_out)
   );

   assign in_addr     = rd_addr;
   assign in_ch       = ic;
   assign kernel_addr = kaddr;
   assign bias_addr   = oc;
   assign out_addr    = wr_addr;
   assign out_ch      = oc;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer on a 4x3 plane (6x5 padded).
module tb_conv_layer_sequencer;

   localparam int IMG_W    = 4;
   localparam int IMG_H    = 3;
   localparam int CH_W     = 7;
   localparam int ADDR_W   = 16;
   localparam int KADDR_W  = 14;
   localparam int PIPE_LAT = 4;
   localparam int PW       = IMG_W + 2;
   localparam int PH       = IMG_H + 2;
   localparam int PLANE    = PW * PH;
   localparam int WIN_CNT  = PW * IMG_H - 2;

   logic               clk;
   logic               reset;
   logic               start;
   logic [CH_W-1:0]    cfg_in_ch;
   logic [CH_W-1:0]    cfg_out_ch;
   logic               abort;
   logic               stall;
   logic               busy;
   logic               done;
   logic               in_rd_en;
   logic [ADDR_W-1:0]  in_addr;
   logic [CH_W-1:0]    in_ch;
   logic [KADDR_W-1:0] kernel_addr;
   logic [CH_W-1:0]    bias_addr;
   logic               win_valid;
   logic               acc_first;
   logic               acc_last;
   logic               out_wr_en;
   logic [ADDR_W-1:0]  out_addr;
   logic [CH_W-1:0]    out_ch;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int win_cnt = 0;
   int wr_cnt = 0;
   int done_cnt = 0;

   logic [31:0] rd_q[$];
   logic [31:0] win_q[$];
   logic [31:0] wr_q[$];

   conv_layer_sequencer #(
      .IMG_W    (IMG_W),
      .IMG_H    (IMG_H),
      .CH_W     (CH_W),
      .ADDR_W   (ADDR_W),
      .KADDR_W  (KADDR_W),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cfg_in_ch   (cfg_in_ch),
      .cfg_out_ch  (cfg_out_ch),
      .abort       (abort),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .in_rd_en    (in_rd_en),
      .in_addr     (in_addr),
      .in_ch       (in_ch),
      .kernel_addr (kernel_addr),
      .bias_addr   (bias_addr),
      .win_valid   (win_valid),
      .acc_first   (acc_first),
      .acc_last    (acc_last),
      .out_wr_en   (out_wr_en),
      .out_addr    (out_addr),
      .out_ch      (out_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: every read, window and write a full layer should produce.
   task automatic push_model(input int nin, input int nout);
      int widx;
      logic [31:0] e;
      for (int oc = 0; oc < nout; oc++) begin
         for (int ic = 0; ic < nin; ic++) begin
            for (int a = 0; a < PLANE; a++) rd_q.push_back(32'(a));
            widx = 0;
            for (int k = 0; k < WIN_CNT; k++) begin
               if ((k % PW) < IMG_W) begin
                  e = (32'(ic) << 16) | (32'(oc * nin + ic) << 2) |
                      (32'(ic == 0) << 1) | 32'(ic == nin - 1);
                  win_q.push_back(e);
                  if (ic == nin - 1) begin
                     wr_q.push_back((32'(oc) << 16) | 32'(widx));
                     widx++;
                  end
               end
            end
         end
      end
   endtask

   task automatic pulse_start(input int nin, input int nout);
      @(posedge clk);
      #1;
      cfg_in_ch  = CH_W'(nin);
      cfg_out_ch = CH_W'(nout);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic apply_stimulus(input int nin, input int nout);
      push_model(nin, nout);
      pulse_start(nin, nout);
   endtask

   task automatic clear_counts();
      rd_cnt = 0;
      win_cnt = 0;
      wr_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic flush_queues();
      rd_q.delete();
      win_q.delete();
      wr_q.delete();
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      check_output(tag, 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_read(input int addr, input int bias, input int budget, input string tag);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         if (in_rd_en === 1'b1 && in_addr == ADDR_W'(addr) && bias_addr == CH_W'(bias)) seen = 1'b1;
      end
      check_output(tag, 32'(seen), 32'd1);
   endtask

   task automatic check_run(input string tag, input int nrd, input int nwin, input int nwr, input int ndone);
      check_output({tag, "_reads"}, 32'(rd_cnt), 32'(nrd));
      check_output({tag, "_windows"}, 32'(win_cnt), 32'(nwin));
      check_output({tag, "_writes"}, 32'(wr_cnt), 32'(nwr));
      check_output({tag, "_dones"}, 32'(done_cnt), 32'(ndone));
      check_output({tag, "_leftover"}, 32'(rd_q.size() + win_q.size() + wr_q.size()), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_output({tag, "_strobes"},
                   32'({busy, done, in_rd_en, win_valid, acc_first, acc_last, out_wr_en}), 32'd0);
      check_output({tag, "_in_addr"}, 32'(in_addr), 32'd0);
      check_output({tag, "_kernel_addr"}, 32'(kernel_addr), 32'd0);
      check_output({tag, "_out_addr"}, 32'(out_addr), 32'd0);
      check_output({tag, "_channels"}, 32'({in_ch, bias_addr, out_ch}), 32'd0);
   endtask

   // Scoreboard: pop expected traffic as the DUT produces it.
   always @(negedge clk) begin
      if (!reset) begin
         if (in_rd_en === 1'b1) begin
            rd_cnt++;
            if (rd_q.size() == 0) check_output("rd_unexpected", {16'h1, in_addr}, 32'd0);
            else check_output("rd_addr", 32'(in_addr), rd_q.pop_front());
         end
         if (win_valid === 1'b1) begin
            win_cnt++;
            if (win_q.size() == 0)
               check_output("win_unexpected", {9'h1, in_ch, kernel_addr, acc_first, acc_last}, 32'd0);
            else
               check_output("win_info", {9'd0, in_ch, kernel_addr, acc_first, acc_last}, win_q.pop_front());
         end
         if (out_wr_en === 1'b1) begin
            wr_cnt++;
            if (wr_q.size() == 0) check_output("wr_unexpected", {9'h1, out_ch, out_addr}, 32'd0);
            else check_output("wr_info", {9'd0, out_ch, out_addr}, wr_q.pop_front());
         end
         if (done === 1'b1) done_cnt++;
         if (stall === 1'b1) check_output("stall_strobes", 32'({in_rd_en, win_valid, out_wr_en}), 32'd0);
      end
   end

   // Directed sequence of layer runs.
   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      stall      = 1'b0;
      cfg_in_ch  = '0;
      cfg_out_ch = '0;
      @(negedge clk);
      check_idle_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] single plane");
      clear_counts();
      apply_stimulus(1, 1);
      wait_done(400, "runA_done");
      check_run("runA", 30, 12, 12, 1);

      $display("[TB] three in-channels, two out-channels");
      clear_counts();
      apply_stimulus(3, 2);
      wait_done(800, "runB_done");
      check_run("runB", 180, 72, 24, 1);

      $display("[TB] stall mid-stream");
      clear_counts();
      apply_stimulus(1, 1);
      wait_read(20, 0, 200, "stall_reach");
      @(posedge clk);
      #1;
      stall = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_output("stall_hold_addr", 32'(in_addr), 32'd21);
      end
      @(posedge clk);
      #1;
      stall = 1'b0;
      wait_done(400, "runC_done");
      check_run("runC", 30, 12, 12, 1);

      $display("[TB] abort during drain of second plane");
      clear_counts();
      apply_stimulus(1, 2);
      wait_read(29, 1, 400, "abort_reach");
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(negedge clk);
      check_output("abort_strobes", 32'({in_rd_en, win_valid, out_wr_en, done}), 32'd0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      flush_queues();
      @(negedge clk);
      check_output("abort_idle", 32'(busy), 32'd0);
      repeat (12) @(negedge clk);
      check_run("abort", 60, 23, 20, 0);

      $display("[TB] restart after abort");
      clear_counts();
      apply_stimulus(1, 1);
      wait_done(400, "restart_done");
      check_run("restart", 30, 12, 12, 1);

      $display("[TB] zero out-channels");
      clear_counts();
      pulse_start(2, 0);
      @(negedge clk);
      check_output("zero_load", 32'({busy, done}), 32'b10);
      @(negedge clk);
      check_output("zero_done", 32'({busy, done}), 32'b11);
      repeat (4) @(negedge clk);
      check_run("zero", 0, 0, 0, 1);

      $display("[TB] start while busy");
      clear_counts();
      apply_stimulus(1, 1);
      repeat (10) @(posedge clk);
      pulse_start(5, 5);
      wait_done(400, "busy_start_done");
      check_run("busy_start", 30, 12, 12, 1);
      check_output("busy_start_idle", 32'(busy), 32'd0);

      $display("[TB] async reset mid-fill");
      clear_counts();
      apply_stimulus(1, 1);
      repeat (3) @(posedge clk);
      #2;
      check_output("pre_reset_fill", {15'd0, busy, in_addr}, {15'd0, 1'b1, 16'd2});
      #1;
      reset = 1'b1;
      #1;
      check_idle_outputs("mid_reset");
      flush_queues();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
